// File: rtl/uart_pkg.sv
// Shared UART definitions: frame state encoding, data width and the
// bit-period calculation. Used by uart_tx now and by uart_rx later.
package uart_pkg;

  localparam int unsigned UART_DATA_BITS = 8;

  // One encoding for both directions so the receiver can reuse it.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_tx_state_t;

  // Clock cycles per line bit; truncating division.
  function automatic int unsigned calc_clks_per_bit(input int unsigned clk_freq_hz,
                                                    input int unsigned baud);
    return clk_freq_hz / baud;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period counter. Counts 0..CLKS_PER_BIT-1 while enabled and pulses
// bit_done for one cycle at the terminal count, then wraps to 0.
// clear holds the count at 0 and has priority over enable.
module uart_baud_gen #(
  parameter int unsigned CLKS_PER_BIT = 234
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic bit_done
);

  localparam logic [15:0] LAST_COUNT = 16'(CLKS_PER_BIT - 1);

  // A one-cycle bit period cannot be built, and the counter is 16 bits.
  if (CLKS_PER_BIT < 2) begin : g_too_fast
    $error("uart_baud_gen: CLKS_PER_BIT must be at least 2");
  end
  if (CLKS_PER_BIT > 65536) begin : g_too_slow
    $error("uart_baud_gen: CLKS_PER_BIT does not fit the 16-bit counter");
  end

  logic [15:0] count;

  assign bit_done = enable && !clear && (count == LAST_COUNT);

  // Count the bit period; wrap at the terminal count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      if (bit_done) begin
        count <= '0;
      end else begin
        count <= count + 16'd1;
      end
    end
  end

endmodule

// File: rtl/uart_tx.sv
// Byte-wide UART transmitter: valid/ready byte input, 8N1 frames LSB first
// on TXD. Define UART_TX_PARITY_EN to build 8E1 frames with an even parity
// bit after the data bits.
//
// Timing: the accept edge moves the FSM to START, but the line only falls
// one edge later. A one-cycle launch flag keeps the baud counter cleared in
// that first START cycle, so every state boundary after it coincides with a
// line boundary and IDLE is re-entered exactly when the stop bit ends.
// TXD is a flop loaded with the level of the state being entered.
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = 27000000,
  parameter int unsigned BAUD        = 115200
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [7:0] data,
  input  logic       valid,
  output logic       ready,
  output logic       TXD
);

  localparam int unsigned CLKS_PER_BIT = calc_clks_per_bit(CLK_FREQ_HZ, BAUD);
  localparam logic [2:0]  LAST_BIT     = 3'(UART_DATA_BITS - 1);

  uart_tx_state_t            state, state_next;
  logic [UART_DATA_BITS-1:0] shift, shift_next;
  logic [2:0]                bit_idx, bit_idx_next;
  logic                      txd_next;
  logic                      launch;
  logic                      accept;
  logic                      bit_done;
  logic                      baud_clear;
  logic                      baud_enable;
`ifdef UART_TX_PARITY_EN
  logic                      parity;
`endif

  assign ready       = (state == IDLE);
  assign accept      = valid && ready;
  assign baud_clear  = (state == IDLE) || launch;
  assign baud_enable = (state != IDLE);

  uart_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud_gen (
    .clk      (CLK),
    .rst_n    (RESET),
    .clear    (baud_clear),
    .enable   (baud_enable),
    .bit_done (bit_done)
  );

  // Next-state, shift register, bit index and next line level.
  always_comb begin
    state_next   = state;
    shift_next   = shift;
    bit_idx_next = bit_idx;
    txd_next     = 1'b1;

    case (state)
      IDLE: begin
        if (accept) begin
          state_next   = START;
          shift_next   = data;
          bit_idx_next = '0;
        end
      end
      START: begin
        if (bit_done) begin
          state_next = DATA;
        end
      end
      DATA: begin
        if (bit_done) begin
          shift_next   = shift >> 1;
          bit_idx_next = bit_idx + 3'd1;
          if (bit_idx == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
            state_next = PARITY;
`else
            state_next = STOP;
`endif
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_done) begin
          state_next = STOP;
        end
      end
`endif
      STOP: begin
        if (bit_done) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    // The line stays high through the accept cycle, then follows the
    // state being entered.
    if (state != IDLE) begin
      case (state_next)
        START:   txd_next = 1'b0;
        DATA:    txd_next = shift_next[0];
`ifdef UART_TX_PARITY_EN
        PARITY:  txd_next = parity;
`endif
        default: txd_next = 1'b1;
      endcase
    end
  end

  // State, datapath and line registers; reset aborts any frame in flight.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state   <= IDLE;
      shift   <= '0;
      bit_idx <= '0;
      launch  <= 1'b0;
      TXD     <= 1'b1;
    end else begin
      state   <= state_next;
      shift   <= shift_next;
      bit_idx <= bit_idx_next;
      launch  <= accept;
      TXD     <= txd_next;
    end
  end

`ifdef UART_TX_PARITY_EN
  // Even parity of the byte, captured when it is accepted.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      parity <= 1'b0;
    end else if (accept) begin
      parity <= ^data;
    end
  end
`endif

endmodule
